// File: rtl/vote_frame_rx.sv
// vote_frame_rx: start/stop serial frame receiver with a one-entry valid/ready holding register
module vote_frame_rx #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 q_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [CNT_W-1:0]     byte_count
);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, BRK = 2'd3;
  logic [1:0] r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic r_valid, r_ferr, r_ovr;
  logic [CNT_W-1:0] r_cnt;
  logic w_last, w_good, w_load;
  always_comb begin
    w_last = r_idx == IW'(DATA_BITS - 1);
    w_good = r_state == STOP && q_in;
    w_load = w_good && (!r_valid || data_ready);
    w_next = r_state == IDLE ? (q_in ? IDLE : DATA) :
             r_state == DATA ? (w_last ? STOP : DATA) :
             r_state == STOP ? (q_in ? IDLE : BRK) :
             (q_in ? IDLE : BRK);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= (r_state == DATA && !w_last) ? r_idx + 1'b1 : '0;
      if (r_state == DATA) r_shift[r_idx] <= q_in;
      r_ferr  <= r_state == STOP && !q_in;
      if (w_load) r_data <= r_shift;
      // a load in the same cycle as an accept keeps the register full
      r_valid <= w_load || (r_valid && !data_ready);
      if (w_good && !w_load) r_ovr <= 1'b1;
      if (r_valid && data_ready) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign byte_count = r_cnt;
endmodule

// File: doc/vote_frame_rx.md
# vote_frame_rx

Serial frame receiver that sits directly downstream of the registered majority-vote/select stage. It consumes that stage's one-bit-per-clock output `q` and recovers asynchronous-style frames: start bit 0, DATA_BITS data bits LSB first, stop bit 1. It delivers each byte through a one-entry valid/ready holding register and reports framing errors, overruns and a count of delivered bytes.

## Interface
- DATA_BITS, 8, data bits per frame (1..16)
- CNT_W, 16, width of delivered-byte counter
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- q_in  in  1  voted serial bit from upstream register, one bit per clock
- data_out  out  DATA_BITS  received data word
- data_valid  out  1  data_out holds an undelivered word
- data_ready  in  1  consumer accepts data_out when data_valid && data_ready at posedge
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  sticky: a completed frame was dropped because holding register was full
- byte_count  out  CNT_W  number of accepted handshakes, modulo 2^CNT_W

## Operation
- Reset (rst=1 at posedge): state IDLE, bit index 0, shift register 0, data_out 0, data_valid 0, frame_err 0, overrun 0, byte_count 0. Reset wins over every other event; a partial frame and a held word are discarded.
- States:
  - IDLE: q_in=0 -> DATA, index=0; q_in=1 -> stay.
  - DATA: shift q_in into bit[index]; index==DATA_BITS-1 -> STOP, else index+1.
  - STOP: q_in=1 -> deliver word, -> IDLE. q_in=0 -> frame_err=1 for one cycle, word discarded, -> BREAK.
  - BREAK: wait for q_in=1 -> IDLE; a 0 line after a bad stop bit is never read as a new start bit.
- Delivery on a good stop bit:
  - holding free (data_valid=0) or being emptied the same cycle (data_valid && data_ready): data_out <= word, data_valid <= 1.
  - otherwise: word dropped, data_out unchanged, overrun <= 1 (cleared only by rst).
- Handshake: data_valid && data_ready at posedge -> byte_count+1 (wraps to 0 after 2^CNT_W-1). data_valid <= 0 unless a new word loads that same cycle. data_out is stable while data_valid=1 and not accepted.
- data_ready while data_valid=0 has no effect.
- frame_err and overrun do not interact with the holding register.

## Timing
- Edge t: start bit sampled in IDLE. Edges t+1..t+DATA_BITS: data bits. Edge t+DATA_BITS+1: stop bit.
- data_valid/data_out update at edge t+DATA_BITS+1 and are visible in the following cycle. The frame_err pulse is asserted in that same cycle.
- Back-to-back frames: the next start bit can be sampled at edge t+DATA_BITS+2. With DATA_BITS=8, the minimum frame period is 10 clocks with no idle bits.
- Consumer latency: combinational-free. data_ready is sampled only at the posedge, and there is no path from data_ready to any output within a cycle.
- Upstream q is registered, so q_in needs no extra synchronizer.

## Test plan
- Reset, then q_in=1 for 20 cycles -> data_valid=0, byte_count=0, frame_err=0, overrun=0 throughout.
- Frame 0,1,0,1,0,0,1,0,1 (start, bits LSB-first 0xA5 → 1,0,1,0,0,1,0,1, stop 1) with data_ready=1 -> data_out=0xA5, data_valid high exactly one cycle after stop edge, byte_count=1.
- Two back-to-back frames 0x3C then 0xFF, data_ready held 0 -> data_out=0x3C stays, second frame dropped, overrun=1. Then data_ready=1 for one cycle -> byte_count=1, data_valid=0.
- Frame 0x81 with stop bit 0, line held 0 for 5 more cycles, then 1, then valid frame 0x42 -> one frame_err pulse, no delivery for 0x81, no false start during the held-0 period, data_out=0x42.
- Same-cycle accept and load: word 0x11 held, data_ready=1 asserted on the exact edge the stop bit of 0x22 is sampled -> byte_count+1, data_out=0x22, data_valid stays 1, overrun=0.
- rst asserted at edge t+4 mid-frame with a held word -> all outputs 0 next cycle. A following full frame 0x5A is received correctly.
